// File: rtl/rc4_search_pkg.sv
// Shared types and defaults for the RC4 key-search controller.
// Holds the top/slot state enums and a small popcount helper.
package rc4_search_pkg;

    localparam int DEFAULT_KEY_W   = 22;
    localparam int DEFAULT_N_CORES = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FOUND,
        EXHAUSTED
    } top_state_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_BUSY,
        C_RETIRED
    } slot_state_t;

    // N_CORES never exceeds 8, so a fixed 8-bit popcount covers every build.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rc4_key_search_ctrl_if.sv
// Bundle of the search controller's command, core-handshake and status signals.
// master = the controller, slave = the environment (host plus cracking cores).
interface rc4_key_search_ctrl_if
    import rc4_search_pkg::*;
#(
    parameter int KEY_W   = DEFAULT_KEY_W,
    parameter int N_CORES = DEFAULT_N_CORES
);
    localparam int FC_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic                       start;
    logic                       abort;
    logic [N_CORES-1:0]         core_done;
    logic [N_CORES-1:0]         core_valid;
    logic [N_CORES-1:0]         core_start;
    logic [N_CORES*KEY_W-1:0]   core_key;
    logic [N_CORES-1:0]         core_abort;
    logic                       busy;
    logic                       found;
    logic                       exhausted;
    logic [KEY_W-1:0]           found_key;
    logic [FC_W-1:0]            found_core;
    logic [KEY_W:0]             keys_tried;
    logic [9:0]                 LED_on;

    modport master (
        input  start, abort, core_done, core_valid,
        output core_start, core_key, core_abort, busy, found, exhausted,
               found_key, found_core, keys_tried, LED_on
    );

    modport slave (
        output start, abort, core_done, core_valid,
        input  core_start, core_key, core_abort, busy, found, exhausted,
               found_key, found_core, keys_tried, LED_on
    );

endinterface

// File: rtl/rc4_core_slot.sv
// One core slot: owns the key currently assigned to a cracking core and
// tracks whether that core is idle, busy on a key, or retired for this search.
module rc4_core_slot
    import rc4_search_pkg::*;
#(
    parameter int             KEY_W   = DEFAULT_KEY_W,
    parameter int             N_CORES = DEFAULT_N_CORES,
    parameter logic [KEY_W:0] KEY_MAX = {1'b0, {KEY_W{1'b1}}},
    parameter int             IDX     = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             launch,
    input  logic             halt,
    input  logic             accept,
    output logic [KEY_W-1:0] key,
    output logic             core_start,
    output logic             core_abort,
    output logic             busy,
    output logic             retired
);

    localparam logic [KEY_W:0] FIRST_KEY = (KEY_W+1)'(IDX);

    slot_state_t    state;
    logic [KEY_W:0] key_next;

    // One extra bit so stepping past the top of the key space retires instead of wrapping.
    assign key_next = {1'b0, key} + (KEY_W+1)'(N_CORES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= C_IDLE;
            key        <= '0;
            core_start <= 1'b0;
            core_abort <= 1'b0;
        end else begin
            core_start <= 1'b0;
            core_abort <= 1'b0;
            if (launch) begin
                key <= FIRST_KEY[KEY_W-1:0];
                if (FIRST_KEY <= KEY_MAX) begin
                    state      <= C_BUSY;
                    core_start <= 1'b1;
                end else begin
                    state <= C_RETIRED;
                end
            end else if (halt) begin
                // A core that just reported has already stopped and needs no kill.
                if (state == C_BUSY) begin
                    state      <= C_IDLE;
                    core_abort <= !accept;
                end
            end else if (accept) begin
                if (key_next <= KEY_MAX) begin
                    key        <= key_next[KEY_W-1:0];
                    core_start <= 1'b1;
                end else begin
                    state <= C_RETIRED;
                end
            end
        end
    end

    assign busy    = (state == C_BUSY);
    assign retired = (state == C_RETIRED);

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Top of the RC4 key search: hands interleaved keys to N_CORES cracking cores,
// collects their verdicts and reports the winning key or an exhausted range.
module rc4_key_search_ctrl
    import rc4_search_pkg::*;
#(
    parameter int             KEY_W   = DEFAULT_KEY_W,
    parameter int             N_CORES = DEFAULT_N_CORES,
    parameter logic [KEY_W:0] KEY_MAX = {1'b0, {KEY_W{1'b1}}}
) (
    input  logic                      clk,
    input  logic                      reset_n,
    rc4_key_search_ctrl_if.master     bus
);

    localparam int FC_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    top_state_t         state;
    logic               busy;
    logic               found;
    logic               exhausted;
    logic [KEY_W-1:0]   found_key;
    logic [FC_W-1:0]    found_core;
    logic [KEY_W:0]     keys_tried;

    logic [KEY_W-1:0]   slot_key [N_CORES];
    logic [N_CORES-1:0] slot_busy;
    logic [N_CORES-1:0] slot_retired;
    logic [N_CORES-1:0] start_vec;
    logic [N_CORES-1:0] abort_vec;
    logic [N_CORES-1:0] accepted;

    logic               in_run;
    logic               launch;
    logic               win_any;
    logic               halt;
    logic               all_retired;
    logic [FC_W-1:0]    win_idx;
    logic [KEY_W-1:0]   win_key;
    logic [KEY_W+1:0]   tried_sum;
    logic [KEY_W:0]     tried_next;

    assign in_run      = (state == RUN);
    assign launch      = bus.start && !in_run;
    assign accepted    = in_run ? (bus.core_done & slot_busy) : '0;
    assign win_any     = |(accepted & bus.core_valid);
    assign halt        = in_run && (bus.abort || win_any);
    assign all_retired = &slot_retired;

    // Scan downwards so the lowest-indexed valid core wins a tie.
    always_comb begin
        win_idx = '0;
        win_key = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (accepted[i] && bus.core_valid[i]) begin
                win_idx = FC_W'(i);
                win_key = slot_key[i];
            end
        end
    end

    assign tried_sum  = {1'b0, keys_tried} + (KEY_W+2)'(popcount8(8'(accepted)));
    assign tried_next = tried_sum[KEY_W+1] ? {(KEY_W+1){1'b1}} : tried_sum[KEY_W:0];

    generate
        for (genvar g = 0; g < N_CORES; g++) begin : g_slot
            rc4_core_slot #(
                .KEY_W   (KEY_W),
                .N_CORES (N_CORES),
                .KEY_MAX (KEY_MAX),
                .IDX     (g)
            ) u_slot (
                .clk        (clk),
                .reset_n    (reset_n),
                .launch     (launch),
                .halt       (halt),
                .accept     (accepted[g]),
                .key        (slot_key[g]),
                .core_start (start_vec[g]),
                .core_abort (abort_vec[g]),
                .busy       (slot_busy[g]),
                .retired    (slot_retired[g])
            );
            assign bus.core_key[g*KEY_W +: KEY_W] = slot_key[g];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            found_key  <= '0;
            found_core <= '0;
            keys_tried <= '0;
        end else begin
            case (state)
                RUN: begin
                    keys_tried <= tried_next;
                    // Abort outranks a same-cycle hit or exhaustion.
                    if (bus.abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (win_any) begin
                        state      <= FOUND;
                        busy       <= 1'b0;
                        found      <= 1'b1;
                        found_key  <= win_key;
                        found_core <= win_idx;
                    end else if (all_retired) begin
                        state     <= EXHAUSTED;
                        busy      <= 1'b0;
                        exhausted <= 1'b1;
                    end
                end
                default: begin
                    if (bus.start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        found      <= 1'b0;
                        exhausted  <= 1'b0;
                        keys_tried <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.core_start = start_vec;
    assign bus.core_abort = abort_vec;
    assign bus.busy       = busy;
    assign bus.found      = found;
    assign bus.exhausted  = exhausted;
    assign bus.found_key  = found_key;
    assign bus.found_core = found_core;
    assign bus.keys_tried = keys_tried;
    assign bus.LED_on     = {found ? found_key[6:0] : keys_tried[KEY_W -: 7],
                             exhausted, found, busy};

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: two instances (KEY_MAX 15 and 2) share one
// stimulus stream and are checked every cycle against a behavioural search model.
module tb_rc4_key_search_ctrl;

    localparam int KW = 8;
    localparam int NC = 4;

    localparam logic [1:0] M_IDLE  = 2'd0;
    localparam logic [1:0] M_RUN   = 2'd1;
    localparam logic [1:0] M_FOUND = 2'd2;
    localparam logic [1:0] M_EXH   = 2'd3;

    typedef struct packed {
        logic [1:0]       mode;
        logic [3:0][7:0]  key;
        logic [3:0]       busy;
        logic [3:0]       retired;
        logic [3:0]       st;
        logic [3:0]       ab;
        logic [7:0]       fkey;
        logic [1:0]       fcore;
        logic [8:0]       tried;
    } mdl_t;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [3:0] core_done;
    logic [3:0] core_valid;

    int n_checks;
    int n_errors;

    mdl_t ma;
    mdl_t mb;

    rc4_key_search_ctrl_if #(.KEY_W(KW), .N_CORES(NC)) ifa ();
    rc4_key_search_ctrl_if #(.KEY_W(KW), .N_CORES(NC)) ifb ();

    assign ifa.start      = start;
    assign ifa.abort      = abort;
    assign ifa.core_done  = core_done;
    assign ifa.core_valid = core_valid;
    assign ifb.start      = start;
    assign ifb.abort      = abort;
    assign ifb.core_done  = core_done;
    assign ifb.core_valid = core_valid;

    rc4_key_search_ctrl #(.KEY_W(KW), .N_CORES(NC), .KEY_MAX(9'd15)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifa)
    );

    rc4_key_search_ctrl #(.KEY_W(KW), .N_CORES(NC), .KEY_MAX(9'd2)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Search rules at the key-space level: next cycle's outputs from this cycle's inputs.
    function automatic mdl_t step(input mdl_t m, input logic s, input logic a,
                                  input logic [3:0] d, input logic [3:0] v, input int kmax);
        mdl_t       n;
        logic [3:0] acc;
        int         t;
        int         w;
        int         nk;
        n    = m;
        n.st = '0;
        n.ab = '0;
        if (m.mode != M_RUN) begin
            if (s) begin
                n.mode  = M_RUN;
                n.tried = '0;
                for (int i = 0; i < 4; i++) begin
                    n.key[i] = 8'(i);
                    if (i <= kmax) begin
                        n.busy[i]    = 1'b1;
                        n.retired[i] = 1'b0;
                        n.st[i]      = 1'b1;
                    end else begin
                        n.busy[i]    = 1'b0;
                        n.retired[i] = 1'b1;
                    end
                end
            end
        end else begin
            acc = d & m.busy;
            t   = int'(m.tried) + $countones(acc);
            n.tried = (t > 511) ? 9'd511 : 9'(t);
            if (a) begin
                n.mode = M_IDLE;
                n.ab   = m.busy & ~acc;
                n.busy = '0;
            end else if ((acc & v) != 4'b0000) begin
                w = 0;
                for (int i = 3; i >= 0; i--) if (acc[i] && v[i]) w = i;
                n.mode  = M_FOUND;
                n.fkey  = m.key[w];
                n.fcore = 2'(w);
                n.ab    = m.busy & ~acc;
                n.busy  = '0;
            end else if (m.retired == 4'b1111) begin
                n.mode = M_EXH;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (acc[i]) begin
                        nk = int'(m.key[i]) + 4;
                        if (nk <= kmax) begin
                            n.key[i] = 8'(nk);
                            n.st[i]  = 1'b1;
                        end else begin
                            n.busy[i]    = 1'b0;
                            n.retired[i] = 1'b1;
                        end
                    end
                end
            end
        end
        return n;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag, input mdl_t m,
                               input logic [3:0] st, input logic [3:0] ab, input logic [31:0] ck,
                               input logic bsy, input logic fnd, input logic exh,
                               input logic [7:0] fk, input logic [1:0] fc,
                               input logic [8:0] kt, input logic [9:0] led);
        logic [9:0] eled;
        eled = {(m.mode == M_FOUND) ? m.fkey[6:0] : m.tried[8:2],
                m.mode == M_EXH, m.mode == M_FOUND, m.mode == M_RUN};
        check_output({tag, ".core_start"}, 32'(st),  32'(m.st));
        check_output({tag, ".core_abort"}, 32'(ab),  32'(m.ab));
        check_output({tag, ".core_key"},   ck,       32'(m.key));
        check_output({tag, ".busy"},       32'(bsy), 32'(m.mode == M_RUN));
        check_output({tag, ".found"},      32'(fnd), 32'(m.mode == M_FOUND));
        check_output({tag, ".exhausted"},  32'(exh), 32'(m.mode == M_EXH));
        check_output({tag, ".found_key"},  32'(fk),  32'(m.fkey));
        check_output({tag, ".found_core"}, 32'(fc),  32'(m.fcore));
        check_output({tag, ".keys_tried"}, 32'(kt),  32'(m.tried));
        check_output({tag, ".LED_on"},     32'(led), 32'(eled));
    endtask

    // Per-cycle comparison on the falling edge, then advance the models.
    always @(negedge clk) begin
        if (!reset_n) begin
            ma = '0;
            mb = '0;
        end
        check_model("a", ma, ifa.core_start, ifa.core_abort, ifa.core_key, ifa.busy, ifa.found,
                    ifa.exhausted, ifa.found_key, ifa.found_core, ifa.keys_tried, ifa.LED_on);
        check_model("b", mb, ifb.core_start, ifb.core_abort, ifb.core_key, ifb.busy, ifb.found,
                    ifb.exhausted, ifb.found_key, ifb.found_core, ifb.keys_tried, ifb.LED_on);
        if (reset_n) begin
            ma = step(ma, start, abort, core_done, core_valid, 15);
            mb = step(mb, start, abort, core_done, core_valid, 2);
        end
    end

    task automatic apply_stimulus(input logic s, input logic a, input logic [3:0] d, input logic [3:0] v);
        start      = s;
        abort      = a;
        core_done  = d;
        core_valid = v;
        @(posedge clk);
        #1;
        start      = 1'b0;
        abort      = 1'b0;
        core_done  = 4'b0000;
        core_valid = 4'b0000;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] rv;
        n_checks   = 0;
        n_errors   = 0;
        ma         = '0;
        mb         = '0;
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        core_done  = 4'b0000;
        core_valid = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_leds", 32'(ifa.LED_on), 32'h0);
        check_output("reset_tried", 32'(ifa.keys_tried), 32'h0);
        reset_n = 1'b1;
        idle_cycles(2);

        // Full sweep with every core reporting a miss each round.
        apply_stimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
        check_output("b_first_starts", 32'(ifb.core_start), 32'h7);
        for (int r = 0; r < 4; r++) begin
            check_output("sweep_starts", 32'(ifa.core_start), 32'hf);
            check_output("sweep_keys", ifa.core_key,
                         {8'(4*r+3), 8'(4*r+2), 8'(4*r+1), 8'(4*r)});
            idle_cycles(1);
            apply_stimulus(1'b0, 1'b0, 4'b1111, 4'b0000);
        end
        idle_cycles(1);
        check_output("sweep_exhausted", 32'(ifa.exhausted), 32'h1);
        check_output("sweep_tried", 32'(ifa.keys_tried), 32'd16);
        check_output("sweep_led", 32'(ifa.LED_on), 32'h024);
        check_output("b_exhausted", 32'(ifb.exhausted), 32'h1);
        check_output("b_tried", 32'(ifb.keys_tried), 32'd3);

        // Core 2 hits on key 6.
        apply_stimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
        idle_cycles(1);
        apply_stimulus(1'b0, 1'b0, 4'b1111, 4'b0000);
        idle_cycles(1);
        apply_stimulus(1'b0, 1'b0, 4'b0100, 4'b0100);
        check_output("hit_found", 32'(ifa.found), 32'h1);
        check_output("hit_key", 32'(ifa.found_key), 32'd6);
        check_output("hit_core", 32'(ifa.found_core), 32'd2);
        check_output("hit_abort", 32'(ifa.core_abort), 32'hb);
        check_output("hit_led", 32'(ifa.LED_on), 32'h032);
        idle_cycles(1);
        check_output("hit_abort_once", 32'(ifa.core_abort), 32'h0);

        // Cores 1 and 3 hit together on keys 5 and 7.
        apply_stimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
        idle_cycles(1);
        apply_stimulus(1'b0, 1'b0, 4'b1111, 4'b0000);
        idle_cycles(1);
        apply_stimulus(1'b0, 1'b0, 4'b1010, 4'b1010);
        check_output("tie_core", 32'(ifa.found_core), 32'd1);
        check_output("tie_key", 32'(ifa.found_key), 32'd5);
        check_output("tie_abort", 32'(ifa.core_abort), 32'h5);

        // Abort after five completed keys.
        apply_stimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
        idle_cycles(1);
        apply_stimulus(1'b0, 1'b0, 4'b1111, 4'b0000);
        idle_cycles(1);
        apply_stimulus(1'b0, 1'b0, 4'b0001, 4'b0000);
        idle_cycles(1);
        apply_stimulus(1'b1, 1'b1, 4'b0000, 4'b0000);
        check_output("abort_busy", 32'(ifa.busy), 32'h0);
        check_output("abort_tried", 32'(ifa.keys_tried), 32'd5);
        check_output("abort_kill", 32'(ifa.core_abort), 32'hf);
        check_output("abort_no_start", 32'(ifa.core_start), 32'h0);

        // Reset in the middle of a run.
        apply_stimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
        idle_cycles(1);
        apply_stimulus(1'b0, 1'b0, 4'b1111, 4'b0000);
        reset_n = 1'b0;
        #1;
        check_output("rst_start", 32'(ifa.core_start), 32'h0);
        check_output("rst_abort", 32'(ifa.core_abort), 32'h0);
        check_output("rst_busy", 32'(ifa.busy), 32'h0);
        check_output("rst_keys", ifa.core_key, 32'h0);
        check_output("rst_led", 32'(ifa.LED_on), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply_stimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
        check_output("restart_keys", ifa.core_key, 32'h03020100);
        check_output("restart_starts", 32'(ifa.core_start), 32'hf);

        // Randomized traffic, including stray dones, restarts and aborts.
        for (int k = 0; k < 600; k++) begin
            rv = 4'b0000;
            for (int i = 0; i < 4; i++) rv[i] = ($urandom_range(0, 11) == 0);
            if (k == 300) pulse_reset();
            apply_stimulus($urandom_range(0, 14) == 0, $urandom_range(0, 39) == 0,
                           4'($urandom), rv);
        end
        idle_cycles(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
